// File: rtl/cv32e40p_cnn_pkg.sv
// Shared types and sizing for the CNN bit-plane datapath.
// The combiner and the plane accumulator both depend on these widths.
package cv32e40p_cnn_pkg;

  localparam int CNN_NUM_CH     = 16;
  localparam int CNN_NUM_PLANES = 8;
  localparam int CNN_ACC_W      = 16;
  localparam int CNN_IN_W       = 12;

  typedef logic signed [CNN_ACC_W-1:0] cnn_acc_t;
  typedef cnn_acc_t [CNN_NUM_CH-1:0]   cnn_plane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FULL = 2'd2
  } cnn_acc_state_e;

endpackage

// File: rtl/cv32e40p_cnn_sat_add.sv
// Single-channel signed accumulate with clamp to the ACC_W range.
// Purely combinational; sat flags that the clamp was applied.
module cv32e40p_cnn_sat_add #(
  parameter int IN_W  = 12,
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [IN_W-1:0]  psum,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sat
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - IN_W){psum[IN_W-1]}}, psum};
    // The two top bits disagree only when the true sum left the ACC_W range.
    sat  = wide[ACC_W] ^ wide[ACC_W-1];
    sum  = sat ? {wide[ACC_W], {(ACC_W - 1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/cv32e40p_cnn_plane_acc.sv
// Per-plane, per-channel partial-sum cache feeding the bit-plane combiner.
// valid_o rises one cycle after the last beat; ready_o drops only in FULL while ready_i is low.
module cv32e40p_cnn_plane_acc
  import cv32e40p_cnn_pkg::*;
#(
  parameter int NUM_CH     = CNN_NUM_CH,
  parameter int NUM_PLANES = CNN_NUM_PLANES,
  parameter int IN_W       = CNN_IN_W,
  parameter int ACC_W      = CNN_ACC_W
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             clear_i,
  input  logic                                             valid_i,
  output logic                                             ready_o,
  input  logic [2:0]                                       plane_i,
  input  logic                                             last_i,
  input  logic signed [NUM_CH-1:0][IN_W-1:0]               psum_i,
  output logic                                             valid_o,
  input  logic                                             ready_i,
  output logic                                             mode_o,
  output logic signed [NUM_PLANES-1:0][NUM_CH-1:0][ACC_W-1:0] cache_o,
  output logic                                             sat_o
);

  cnn_acc_state_e state_q, state_d;

  logic [NUM_PLANES-1:0][NUM_CH-1:0][ACC_W-1:0] cache_q, cache_d;
  logic                                         sat_q, sat_d;
  logic [NUM_CH-1:0][ACC_W-1:0]                 base_row, sum_row;
  logic [NUM_CH-1:0]                            sat_vec;
  logic                                         plane_ok;
  logic                                         acc_fire, out_fire;

  generate
    if (NUM_PLANES >= 8) begin : g_all_planes
      assign plane_ok = 1'b1;
    end else begin : g_plane_chk
      assign plane_ok = (32'(plane_i) < NUM_PLANES);
    end
  endgenerate

  assign acc_fire = valid_i && ready_o && !clear_i;
  assign out_fire = valid_o && ready_i && !clear_i;

  // A drain in the same cycle means the beat lands on an all-zero cache.
  assign base_row = out_fire ? '0 : cache_q[plane_i];

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      cv32e40p_cnn_sat_add #(
        .IN_W (IN_W),
        .ACC_W(ACC_W)
      ) u_sat_add (
        .acc (base_row[c]),
        .psum($signed(psum_i[c])),
        .sum (sum_row[c]),
        .sat (sat_vec[c])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (acc_fire) state_d = last_i ? FULL : ACC;
        end
        FULL: begin
          if (out_fire) begin
            if (acc_fire) state_d = last_i ? FULL : ACC;
            else          state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_o = (state_q == FULL);
    mode_o  = (state_q == FULL);
    ready_o = (state_q != FULL) || ready_i;
  end

  always_comb begin
    cache_d = cache_q;
    sat_d   = sat_q;
    if (clear_i) begin
      cache_d = '0;
      sat_d   = 1'b0;
    end else if (out_fire) begin
      cache_d = '0;
      sat_d   = 1'b0;
      if (acc_fire && plane_ok) begin
        cache_d[plane_i] = sum_row;
        sat_d            = |sat_vec;
      end
    end else if (acc_fire && plane_ok) begin
      cache_d[plane_i] = sum_row;
      sat_d            = sat_q | (|sat_vec);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      cache_q <= cache_d;
      sat_q   <= sat_d;
    end
  end

  assign cache_o = cache_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_cv32e40p_cnn_plane_acc.sv
// Scoreboard bench: stimulus pushes expected windows, a negedge monitor checks each drain.
// Reference model keeps the cache as plain integers and clamps with ordinary arithmetic.
module tb_cv32e40p_cnn_plane_acc;

  logic                    clk = 1'b0;
  logic                    rst, clear_i, valid_i, ready_o, last_i;
  logic                    valid_o, ready_i, mode_o, sat_o;
  logic [2:0]              plane_i;
  logic [15:0][11:0]       psum_i;
  logic [7:0][15:0][15:0]  cache_o;

  cv32e40p_cnn_plane_acc dut (
    .clk    (clk),
    .rst    (rst),
    .clear_i(clear_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .plane_i(plane_i),
    .last_i (last_i),
    .psum_i (psum_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .mode_o (mode_o),
    .cache_o(cache_o),
    .sat_o  (sat_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][15:0][15:0] c;
    logic                   s;
  } win_t;

  win_t exp_q[$];
  int   mc[8][16];
  bit   msat;
  int   beat_ps[16];
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_window(input string nm, input win_t w);
    int bp = -1;
    int bc = -1;
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 16; c++)
        if (bp < 0 && cache_o[p][c] !== w.c[p][c]) begin
          bp = p;
          bc = c;
        end
    n_cmp++;
    if (bp >= 0) begin
      n_err++;
      $display("FAIL %s cache[%0d][%0d]: got %0d expected %0d", nm, bp, bc,
               $signed(cache_o[bp][bc]), $signed(w.c[bp][bc]));
    end
    chk({nm, "_sat"}, sat_o, w.s);
  endtask

  function automatic void model_zero();
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 16; c++) mc[p][c] = 0;
    msat = 1'b0;
  endfunction

  function automatic win_t model_snap();
    win_t w;
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 16; c++) w.c[p][c] = 16'(mc[p][c]);
    w.s = msat;
    return w;
  endfunction

  function automatic void model_accept(input int pl, input bit last);
    for (int c = 0; c < 16; c++) begin
      int s = mc[pl][c] + beat_ps[c];
      if (s > 32767) begin s = 32767; msat = 1'b1; end
      if (s < -32768) begin s = -32768; msat = 1'b1; end
      mc[pl][c] = s;
    end
    if (last) begin
      exp_q.push_back(model_snap());
      model_zero();
    end
  endfunction

  task automatic fill(input int v);
    for (int c = 0; c < 16; c++) beat_ps[c] = v;
  endtask

  task automatic fill_rand();
    for (int c = 0; c < 16; c++) beat_ps[c] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  task automatic drive(input int pl, input bit last);
    valid_i = 1'b1;
    plane_i = 3'(pl);
    last_i  = last;
    for (int c = 0; c < 16; c++) psum_i[c] = 12'(beat_ps[c]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int pl, input bit last);
    bit ok = 1'b0;
    drive(pl, last);
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (ready_o) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: beat plane %0d never accepted, required within 64 cycles", pl);
    end else begin
      model_accept(pl, last);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic win1();
    fill(5);  send(0, 1'b0);
    fill(3);  send(0, 1'b0);
    fill(-2); send(7, 1'b1);
    @(negedge clk);
    chk("w1_valid", valid_o, 1);
    chk("w1_mode", mode_o, 1);
    chk("w1_p0", $signed(cache_o[0][3]), 8);
    chk("w1_p7", $signed(cache_o[7][9]), -2);
    chk("w1_p4", $signed(cache_o[4][0]), 0);
    chk("w1_sat", sat_o, 0);
    step();
  endtask

  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       ready_i = 1'b0;
        1:       ready_i = 1'b1;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    win_t w;
    forever begin
      @(negedge clk);
      if (!rst && !clear_i && valid_o && ready_i) begin
        chk("drain_mode", mode_o, 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_window: valid_o=1 with no window expected");
        end else begin
          w = exp_q.pop_front();
          cmp_window("drain", w);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    win_t zero_w;
    zero_w  = '0;
    rst     = 1'b1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    plane_i = '0;
    psum_i  = '0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_mode", mode_o, 0);
    cmp_window("rst_cache", zero_w);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready_o, 1);
    step();

    rdy_mode = 1;
    win1();

    // Backpressure with a beat waiting.
    rdy_mode = 0;
    fill_rand(); send(4, 1'b0);
    fill_rand(); send(6, 1'b1);
    fill(11);
    drive(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", ready_o, 0);
      chk("bp_valid", valid_o, 1);
      cmp_window("bp_hold", exp_q[0]);
      step();
    end
    rdy_mode = 1;
    send(1, 1'b0);
    @(negedge clk);
    chk("bp_after_valid", valid_o, 0);
    step();
    fill(1); send(1, 1'b1);

    // Saturation in both directions; psum is 12-bit so extremes are +2047/-2048.
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 16; c++) beat_ps[c] = int'($urandom_range(0, 200)) - 100;
      beat_ps[5] = 2047;
      send(3, i == 19);
    end
    @(negedge clk);
    chk("sat_pos", $signed(cache_o[3][5]), 32767);
    chk("sat_pos_flag", sat_o, 1);
    step();
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 16; c++) beat_ps[c] = int'($urandom_range(0, 200)) - 100;
      beat_ps[5] = -2048;
      send(3, i == 19);
    end
    @(negedge clk);
    chk("sat_neg", $signed(cache_o[3][5]), -32768);
    chk("sat_neg_flag", sat_o, 1);
    step();

    // Drain and accept a last beat in the same cycle.
    rdy_mode = 0;
    fill_rand(); send(5, 1'b1);
    rdy_mode = 1;
    fill(7); send(2, 1'b1);
    @(negedge clk);
    chk("da_valid", valid_o, 1);
    chk("da_p2", $signed(cache_o[2][0]), 7);
    chk("da_p2b", $signed(cache_o[2][15]), 7);
    chk("da_p5", $signed(cache_o[5][3]), 0);
    chk("da_sat", sat_o, 0);
    step();

    // clear_i beats a last beat and ready_i.
    fill_rand(); send(0, 1'b0);
    fill_rand(); send(3, 1'b0);
    fill_rand(); drive(6, 1'b1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    model_zero();
    exp_q.delete();
    @(negedge clk);
    chk("clr_valid", valid_o, 0);
    cmp_window("clr_cache", zero_w);
    step();

    // clear_i while holding a completed window.
    rdy_mode = 0;
    fill_rand(); send(1, 1'b1);
    rdy_mode = 1;
    clear_i  = 1'b1;
    step();
    clear_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("clr_full_valid", valid_o, 0);
    cmp_window("clr_full_cache", zero_w);
    step();

    // Async reset between edges while FULL with sat set.
    rdy_mode = 0;
    fill(2047);
    for (int i = 0; i < 17; i++) send(0, i == 16);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_mode", mode_o, 0);
    cmp_window("arst_cache", zero_w);
    exp_q.delete();
    model_zero();
    step();
    rst = 1'b0;
    #1;
    chk("arst_ready", ready_o, 1);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    win1();

    // Randomized windows with random backpressure.
    rdy_mode = 2;
    for (int w = 0; w < 40; w++) begin
      bit ext;
      int hot, nb;
      bit sgn[16];
      ext = 1'($urandom_range(0, 1));
      hot = int'($urandom_range(0, 7));
      nb  = int'($urandom_range(1, ext ? 24 : 8));
      for (int c = 0; c < 16; c++) sgn[c] = 1'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        int pl;
        pl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : hot;
        for (int c = 0; c < 16; c++)
          beat_ps[c] = ext ? (sgn[c] ? -2048 : 2047 - int'($urandom_range(0, 15)))
                           : int'($urandom_range(0, 4095)) - 2048;
        if ($urandom_range(0, 3) == 0) step();
        send(pl, b == nb - 1);
      end
    end

    rdy_mode = 1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    chk("final_pending", exp_q.size(), 0);
    @(negedge clk);
    chk("final_valid", valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
